cam_tx_ov7670: RTL and testbench

//  Frame-buffer-to-camera-bus transmitter: reads RGB332 pixels from a sync-read pixel memory and

---
 rtl/cam_pkg.sv | 31 +++
 rtl/rgb332_to_rgb565.sv | 26 ++
 rtl/cam_tx_ov7670.sv | 210 +++++++++++++++++++++
 tb/tb_cam_tx_ov7670.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Camera bus shared types: transmitter FSM encoding, RGB332/RGB565 field widths,
// and the colour-bar pixel helper. Imported by cam_tx_ov7670 and its converter.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VFRONT,
    ST_DONE
  } cam_state_e;

  localparam int RGB332_W = 8;
  localparam int RGB565_W = 16;
  localparam int R3_W     = 3;
  localparam int G3_W     = 3;
  localparam int B2_W     = 2;
  localparam int R5_W     = 5;
  localparam int G6_W     = 6;
  localparam int B5_W     = 5;

  // Colour bar pixel: each bar-index bit replicated over one colour field.
  function automatic logic [RGB332_W-1:0] bar_rgb332(
    input logic [2:0] bar
  );
    return {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
  endfunction

endpackage

// File: rtl/rgb332_to_rgb565.sv
// Combinational RGB332 -> RGB565 expansion by bit replication.
// Ports: i_rgb332 (8, {R3,G3,B2}), o_rgb565 (16, {R5,G6,B5}).
module rgb332_to_rgb565
  import cam_pkg::*;
(
  input  logic [RGB332_W-1:0] i_rgb332,
  output logic [RGB565_W-1:0] o_rgb565
);

  logic [R3_W-1:0] w_r;
  logic [G3_W-1:0] w_g;
  logic [B2_W-1:0] w_b;
  logic [R5_W-1:0] w_r5;
  logic [G6_W-1:0] w_g6;
  logic [B5_W-1:0] w_b5;

  assign {w_r, w_g, w_b} = i_rgb332;

  // Replicating the MSBs into the new LSBs maps full scale to full scale.
  assign w_r5 = {w_r, w_r[2:1]};
  assign w_g6 = {w_g, w_g};
  assign w_b5 = {w_b, w_b, w_b[1]};

  assign o_rgb565 = {w_r5, w_g6, w_b5};

endmodule

// File: rtl/cam_tx_ov7670.sv
// Frame buffer -> OV7670-style camera bus (vsync/href/px_data, RGB565, hi byte first).
// Ports: pclk, rst (async, active-low), start, mem_px_addr/mem_px_data (sync-read RAM),
//   vsync, href, px_data, busy, frame_done. Define CAM_TX_PATTERN_EN for internal colour bars.
module cam_tx_ov7670
  import cam_pkg::*;
#(
  parameter int AW          = 17,
  parameter int H_ACT       = 160,
  parameter int V_ACT       = 120,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2
)(
  input  logic          pclk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] mem_px_addr,
  input  logic [7:0]    mem_px_data,
  output logic          vsync,
  output logic          href,
  output logic [7:0]    px_data,
  output logic          busy,
  output logic          frame_done
);

  localparam int LINE_LEN = 2 * H_ACT + H_BLANK;
  localparam int BW       = $clog2(LINE_LEN);
  localparam int LM1      = (V_ACT > VSYNC_LINES) ? V_ACT : VSYNC_LINES;
  localparam int LM2      = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int LMAX     = (LM1 > LM2) ? LM1 : LM2;
  localparam int LW       = (LMAX > 1) ? $clog2(LMAX) : 1;

  localparam logic [BW-1:0] B_LAST  = BW'(LINE_LEN - 1);
  localparam logic [BW-1:0] B_ALAST = BW'(2 * H_ACT - 1);
  localparam logic [LW-1:0] L_VS    = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] L_VB    = LW'(V_BACK - 1);
  localparam logic [LW-1:0] L_ACT   = LW'(V_ACT - 1);
  localparam logic [LW-1:0] L_VF    = LW'(V_FRONT - 1);

  cam_state_e r_state, w_state_n;
  logic [BW-1:0] r_bcnt, w_bcnt_n;
  logic [LW-1:0] r_lcnt, w_lcnt_n;
  logic [AW-1:0] r_addr, w_addr_n;
  logic          w_eol;

  logic          r_vsync;
  logic          r_href;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_px;

  logic [7:0]    w_pix;
  logic [15:0]   w_rgb565;
  logic [7:0]    w_px_n;

  always_comb begin
    w_state_n = r_state;
    w_bcnt_n  = r_bcnt;
    w_lcnt_n  = r_lcnt;
    w_eol     = (r_bcnt == B_LAST);
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_n = ST_VSYNC;
          w_bcnt_n  = '0;
          w_lcnt_n  = '0;
        end
      end
      ST_VSYNC: begin
        w_bcnt_n = w_eol ? '0 : r_bcnt + BW'(1);
        if (w_eol) begin
          if (r_lcnt == L_VS) begin
            w_state_n = ST_VBACK;
            w_lcnt_n  = '0;
          end else begin
            w_lcnt_n = r_lcnt + LW'(1);
          end
        end
      end
      ST_VBACK: begin
        w_bcnt_n = w_eol ? '0 : r_bcnt + BW'(1);
        if (w_eol) begin
          if (r_lcnt == L_VB) begin
            w_state_n = ST_ACTIVE;
            w_lcnt_n  = '0;
          end else begin
            w_lcnt_n = r_lcnt + LW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        w_bcnt_n = r_bcnt + BW'(1);
        if (r_bcnt == B_ALAST) begin
          w_state_n = ST_HBLANK;
        end
      end
      ST_HBLANK: begin
        w_bcnt_n = w_eol ? '0 : r_bcnt + BW'(1);
        if (w_eol) begin
          if (r_lcnt == L_ACT) begin
            w_state_n = ST_VFRONT;
            w_lcnt_n  = '0;
          end else begin
            w_state_n = ST_ACTIVE;
            w_lcnt_n  = r_lcnt + LW'(1);
          end
        end
      end
      ST_VFRONT: begin
        w_bcnt_n = w_eol ? '0 : r_bcnt + BW'(1);
        if (w_eol) begin
          if (r_lcnt == L_VF) begin
            w_state_n = ST_DONE;
            w_lcnt_n  = '0;
          end else begin
            w_lcnt_n = r_lcnt + LW'(1);
          end
        end
      end
      ST_DONE: begin
        w_bcnt_n = '0;
        w_lcnt_n = '0;
        w_state_n = start ? ST_VSYNC : ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
        w_bcnt_n  = '0;
        w_lcnt_n  = '0;
      end
    endcase
  end

`ifdef CAM_TX_PATTERN_EN
  logic [BW-2:0] w_col;
  logic [2:0]    w_bar;

  // Column of the byte about to go out, so bars line up with href.
  assign w_col = w_bcnt_n[BW-1:1];
  assign w_bar = 3'((int'(w_col) * 8) / H_ACT);
  assign w_pix = bar_rgb332(w_bar);

  always_comb begin
    w_addr_n = '0;
  end
`else
  localparam logic [BW-1:0] B_PRE   = BW'(LINE_LEN - 2);
  localparam logic [BW-1:0] B_LASTF = BW'(2 * H_ACT - 2);
  logic w_fetch;

  // Address leads the bytes by two cycles (RAM read + output register):
  // pixel k is addressed while pixel k-1 is on the bus, and the first
  // pixel of a line during the last two blank cycles.
  assign w_pix = mem_px_data;

  always_comb begin
    w_fetch =
      (w_state_n == ST_ACTIVE && !w_bcnt_n[0] &&
       w_bcnt_n < B_LASTF) ||
      (w_state_n == ST_HBLANK && w_bcnt_n == B_PRE &&
       r_lcnt != L_ACT);
    w_addr_n = r_addr;
    if (r_state != ST_VSYNC && w_state_n == ST_VSYNC) begin
      w_addr_n = '0;
    end else if (w_fetch) begin
      w_addr_n = r_addr + AW'(1);
    end
  end
`endif

  rgb332_to_rgb565 u_conv (
    .i_rgb332 (w_pix),
    .o_rgb565 (w_rgb565)
  );

  assign w_px_n = (w_state_n != ST_ACTIVE) ? 8'h00 :
                  w_bcnt_n[0] ? w_rgb565[7:0] : w_rgb565[15:8];

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_bcnt  <= '0;
      r_lcnt  <= '0;
      r_addr  <= '0;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_px    <= 8'h00;
    end else begin
      r_state <= w_state_n;
      r_bcnt  <= w_bcnt_n;
      r_lcnt  <= w_lcnt_n;
      r_addr  <= w_addr_n;
      r_vsync <= (w_state_n == ST_VSYNC);
      r_href  <= (w_state_n == ST_ACTIVE);
      r_busy  <= (w_state_n != ST_IDLE) && (w_state_n != ST_DONE);
      r_done  <= (w_state_n == ST_DONE);
      r_px    <= w_px_n;
    end
  end

  assign mem_px_addr = r_addr;
  assign vsync       = r_vsync;
  assign href        = r_href;
  assign px_data     = r_px;
  assign busy        = r_busy;
  assign frame_done  = r_done;

endmodule

// File: tb/tb_cam_tx_ov7670.sv
// Bench for cam_tx_ov7670 with a tiny 4x2 frame and an 8-word sync-read RAM.
// Ports: drives pclk/rst/start, models the pixel RAM, observes the camera bus.
module tb_cam_tx_ov7670;

  localparam int LL = 10;
  localparam int FRAME_DONE_AT = 5 * LL;

  logic        pclk;
  logic        rst;
  logic        start;
  logic [16:0] mem_px_addr;
  logic [7:0]  mem_px_data;
  logic        vsync;
  logic        href;
  logic [7:0]  px_data;
  logic        busy;
  logic        frame_done;

  logic [7:0]  ram [8];

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] pix;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;
  vec_t tv [8];

  int vs_rise, vs_len, fd_cyc, first_href;
  int lead_err, blank_err, busy_err;
  int runs [$];
  int gaps [$];
  int aseq [$];
  logic [7:0] bytes [$];

  cam_tx_ov7670 #(
    .AW(17), .H_ACT(4), .V_ACT(2), .H_BLANK(2),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .start       (start),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) begin
    mem_px_data <= (mem_px_addr < 17'd8) ?
      ram[mem_px_addr[2:0]] : 8'hEE;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample_frame(input bit hold, input int pulse_at);
    int run, gap, a1, a2, k;
    logic pv, ph;
    vs_rise = -1; vs_len = 0; fd_cyc = -1; first_href = -1;
    lead_err = 0; blank_err = 0; busy_err = 0;
    runs.delete(); gaps.delete(); aseq.delete(); bytes.delete();
    run = 0; gap = 0; a1 = -1; a2 = -1; pv = 0; ph = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge pclk);
      if (!hold && c == 0) start = 1'b0;
      if (c == pulse_at) start = 1'b1;
      if (c == pulse_at + 1) start = 1'b0;
      if (vsync && !pv) vs_rise = c;
      if (vsync) vs_len++;
      if (aseq.size() == 0 || aseq[$] != int'(mem_px_addr))
        aseq.push_back(int'(mem_px_addr));
      if (href) begin
        if (first_href < 0) first_href = c;
        k = bytes.size() / 2;
        if (a2 != k) lead_err++;
        if (bytes.size() % 2 == 0 && a1 != k) lead_err++;
        bytes.push_back(px_data);
        if (!ph && runs.size() > 0) gaps.push_back(gap);
        run++;
      end else begin
        if (px_data != 8'h00) blank_err++;
        if (ph) begin
          runs.push_back(run);
          run = 0;
          gap = 0;
        end
        gap++;
      end
      if (frame_done) begin
        fd_cyc = c;
        if (busy) busy_err++;
      end else if (!busy) begin
        busy_err++;
      end
      a2 = a1;
      a1 = int'(mem_px_addr);
      pv = vsync;
      ph = href;
      if (frame_done) break;
    end
  endtask

  task automatic check_data(input string tag);
    logic [7:0] b;
    chk({tag, "_nbytes"}, bytes.size(), 16);
    for (int i = 0; i < 8; i++) begin
      b = (2 * i < bytes.size()) ? bytes[2 * i] : 8'hxx;
      chk($sformatf("%s_hi%0d", tag, i), b, tv[i].hi);
      b = (2 * i + 1 < bytes.size()) ? bytes[2 * i + 1] : 8'hxx;
      chk($sformatf("%s_lo%0d", tag, i), b, tv[i].lo);
    end
    chk({tag, "_naddr"}, aseq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_addr%0d", tag, i),
          (i < aseq.size()) ? aseq[i] : -1, i);
    end
    chk({tag, "_lead"}, lead_err, 0);
    chk({tag, "_blank"}, blank_err, 0);
    chk({tag, "_busy"}, busy_err, 0);
  endtask

  task automatic check_timing(input string tag);
    chk({tag, "_vs_rise"}, vs_rise, 0);
    chk({tag, "_vs_len"}, vs_len, LL);
    chk({tag, "_href0"}, first_href, 2 * LL);
    chk({tag, "_nruns"}, runs.size(), 2);
    chk({tag, "_run0"}, (runs.size() > 0) ? runs[0] : -1, 8);
    chk({tag, "_run1"}, (runs.size() > 1) ? runs[1] : -1, 8);
    chk({tag, "_gap"}, (gaps.size() > 0) ? gaps[0] : -1, 2);
    chk({tag, "_done"}, fd_cyc, FRAME_DONE_AT);
  endtask

  initial begin
    int idle_vs, idle_busy, nh;
    bit hit;

    tv[0] = '{8'h00, 8'h00, 8'h00};
    tv[1] = '{8'h01, 8'h00, 8'h0A};
    tv[2] = '{8'hFF, 8'hFF, 8'hFF};
    tv[3] = '{8'hE0, 8'hF8, 8'h00};
    tv[4] = '{8'h1C, 8'h07, 8'hE0};
    tv[5] = '{8'h03, 8'h00, 8'h1F};
    tv[6] = '{8'h92, 8'h94, 8'h95};
    tv[7] = '{8'h6D, 8'h6B, 8'h6A};
    for (int i = 0; i < 8; i++) ram[i] = tv[i].pix;

    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_px", px_data, 0);
    chk("rst_addr", mem_px_addr, 0);
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    chk("idle_busy", busy, 0);

    // Single start pulse; a second pulse mid-frame must be ignored.
    start = 1'b1;
    sample_frame(1'b0, 25);
    check_timing("f1");
    check_data("f1");

    idle_vs = 0;
    idle_busy = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (vsync) idle_vs++;
      if (busy) idle_busy++;
    end
    chk("idle_vsync", idle_vs, 0);
    chk("idle_busyc", idle_busy, 0);

    // start held: second frame follows frame_done by one cycle.
    start = 1'b1;
    sample_frame(1'b1, -5);
    check_timing("f2");
    check_data("f2");
    sample_frame(1'b0, -5);
    check_timing("f3");
    check_data("f3");

    // Async reset in the middle of the second active line.
    repeat (3) @(negedge pclk);
    start = 1'b1;
    nh = 0;
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge pclk);
      start = 1'b0;
      if (href) nh++;
      if (nh == 13) begin
        hit = 1;
        rst = 1'b0;
        #1;
        break;
      end
    end
    chk("mid_rst_hit", hit, 1);
    chk("mid_rst_vsync", vsync, 0);
    chk("mid_rst_href", href, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_px", px_data, 0);
    chk("mid_rst_addr", mem_px_addr, 0);
    @(negedge pclk);
    chk("mid_rst_href2", href, 0);
    chk("mid_rst_busy2", busy, 0);
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    chk("post_rst_busy", busy, 0);

    start = 1'b1;
    sample_frame(1'b0, -5);
    check_timing("f4");
    check_data("f4");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
